// File: rtl/flags_generator_if.sv
// Bus bundle for flags_generator: writeback, load, stack controls and flag outputs.
// The master modport drives the stimulus and receives the flags, the slave is the block itself.
interface flags_generator_if #(
  parameter int WIDTH = 16
);
  logic             issue_set_flags;
  logic             res_valid;
  logic             res_set_flags;
  logic             res_is_sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             flags_load;
  logic [3:0]       flags_load_data;
  logic             flags_push;
  logic             flags_pop;
  logic [3:0]       flags;
  logic             flags_valid;
  logic             stack_empty;
  logic             stack_full;
  logic             err;

  modport master (
    output issue_set_flags, res_valid, res_set_flags, res_is_sub,
    output op_a, op_b, result, carry_out,
    output flags_load, flags_load_data, flags_push, flags_pop,
    input  flags, flags_valid, stack_empty, stack_full, err
  );

  modport slave (
    input  issue_set_flags, res_valid, res_set_flags, res_is_sub,
    input  op_a, op_b, result, carry_out,
    input  flags_load, flags_load_data, flags_push, flags_pop,
    output flags, flags_valid, stack_empty, stack_full, err
  );
endinterface

// File: rtl/flags_generator.sv
// NZCV flag register with outstanding flag-setter tracking, a save/restore stack
// and a direct-load path. All outputs are registered.
module flags_generator #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4,
  parameter int MAX_PEND    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  flags_generator_if.slave bus
);
  localparam int AW   = $clog2(STACK_DEPTH);
  localparam int SP_W = AW + 1;
  localparam int PW   = $clog2(MAX_PEND + 1);

  logic [3:0]      flags_q, flags_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            valid_q, valid_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            err_q, err_d;
  logic [3:0]      stack_mem [STACK_DEPTH];

  logic            alu_upd, do_push, do_pop;
  logic [3:0]      alu_flags;
  logic [AW-1:0]   top_idx;
  logic            msb_a, msb_b, msb_r, v_flag;

  assign msb_a = bus.op_a[WIDTH-1];
  assign msb_b = bus.op_b[WIDTH-1];
  assign msb_r = bus.result[WIDTH-1];
  // op_b is the un-inverted operand, so subtract overflows when the signs differ.
  assign v_flag    = (bus.res_is_sub ? (msb_a != msb_b) : (msb_a == msb_b)) && (msb_r != msb_a);
  assign alu_flags = {msb_r, (bus.result == '0), bus.carry_out, v_flag};
  assign alu_upd   = bus.res_valid && bus.res_set_flags;

  assign do_push = bus.flags_push && !bus.flags_pop && !full_q;
  assign do_pop  = bus.flags_pop && !bus.flags_push && !empty_q;
  assign top_idx = AW'(sp_q - 1'b1);

  always_comb begin
    flags_d = flags_q;
    pend_d  = pend_q;
    sp_d    = sp_q;
    err_d   = err_q;

    if (do_pop)              flags_d = stack_mem[top_idx];
    else if (bus.flags_load) flags_d = bus.flags_load_data;
    else if (alu_upd)        flags_d = alu_flags;

    if (bus.flags_push && bus.flags_pop)                 err_d = 1'b1;
    else if (bus.flags_push && full_q)                   err_d = 1'b1;
    else if (bus.flags_pop && empty_q)                   err_d = 1'b1;

    if (do_push) sp_d = sp_q + 1'b1;
    if (do_pop)  sp_d = sp_q - 1'b1;

    if (bus.issue_set_flags && !alu_upd) begin
      if (pend_q == PW'(MAX_PEND)) err_d = 1'b1;
      else                         pend_d = pend_q + 1'b1;
    end else if (alu_upd && !bus.issue_set_flags) begin
      if (pend_q == '0) err_d = 1'b1;
      else              pend_d = pend_q - 1'b1;
    end

    valid_d = (pend_d == '0);
    empty_d = (sp_d == '0);
    full_d  = (sp_d == SP_W'(STACK_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q <= '0;
      pend_q  <= '0;
      valid_q <= 1'b1;
      sp_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      sp_q    <= sp_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset; only the pointer defines what is live.
  always_ff @(posedge clk) begin
    if (reset_n && do_push) stack_mem[sp_q[AW-1:0]] <= flags_q;
  end

  assign bus.flags       = flags_q;
  assign bus.flags_valid = valid_q;
  assign bus.stack_empty = empty_q;
  assign bus.stack_full  = full_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_flags_generator.sv
// Directed-vector bench for flags_generator with hand-computed expectations.
module tb_flags_generator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  flags_generator_if #(.WIDTH(16)) bus ();

  flags_generator #(.WIDTH(16), .STACK_DEPTH(4), .MAX_PEND(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_set_flags = 0; bus.res_valid = 0; bus.res_set_flags = 0;
    bus.res_is_sub = 0; bus.op_a = '0; bus.op_b = '0; bus.result = '0;
    bus.carry_out = 0; bus.flags_load = 0; bus.flags_load_data = '0;
    bus.flags_push = 0; bus.flags_pop = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic wb(input logic sub, input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] r, input logic c);
    bus.res_valid = 1; bus.res_set_flags = 1; bus.res_is_sub = sub;
    bus.op_a = a; bus.op_b = b; bus.result = r; bus.carry_out = c;
  endtask

  task automatic load(input logic [3:0] v);
    bus.flags_load = 1; bus.flags_load_data = v;
  endtask

  task automatic step();
    tick();
    idle();
  endtask

  initial begin
    idle();
    tick();
    do_reset();
    repeat (3) tick();
    check("rst_flags", 16'(bus.flags), 16'h0);
    check("rst_valid", 16'(bus.flags_valid), 16'h1);
    check("rst_empty", 16'(bus.stack_empty), 16'h1);
    check("rst_full",  16'(bus.stack_full), 16'h0);
    check("rst_err",   16'(bus.err), 16'h0);

    // issue, then writeback two cycles later
    bus.issue_set_flags = 1; step();
    check("pend_t1_valid", 16'(bus.flags_valid), 16'h0);
    step();
    check("pend_t2_valid", 16'(bus.flags_valid), 16'h0);
    check("pend_t2_flags", 16'(bus.flags), 16'h0);
    wb(0, 16'h7FFF, 16'h0001, 16'h8000, 0); step();
    check("add_ovf_flags", 16'(bus.flags), 16'h9);
    check("add_ovf_valid", 16'(bus.flags_valid), 16'h1);
    check("add_ovf_err",   16'(bus.err), 16'h0);

    bus.issue_set_flags = 1; step();
    wb(1, 16'h0005, 16'h0005, 16'h0000, 1); step();
    check("sub_eq_flags", 16'(bus.flags), 16'h6);
    bus.issue_set_flags = 1; step();
    wb(1, 16'h0003, 16'h0005, 16'hFFFE, 0); step();
    check("sub_neg_flags", 16'(bus.flags), 16'h8);
    // signed sub overflow: 8000 - 0001 = 7FFF
    bus.issue_set_flags = 1; step();
    wb(1, 16'h8000, 16'h0001, 16'h7FFF, 1); step();
    check("sub_ovf_flags", 16'(bus.flags), 16'h3);
    check("sub_ovf_err",   16'(bus.err), 16'h0);

    // save/restore sequence
    do_reset();
    load(4'h9); step();
    bus.flags_push = 1; step();
    load(4'h6); step();
    check("ld_flags", 16'(bus.flags), 16'h6);
    bus.flags_push = 1; step();
    check("push2_empty", 16'(bus.stack_empty), 16'h0);
    bus.flags_pop = 1; step();
    check("pop1_flags", 16'(bus.flags), 16'h6);
    bus.flags_pop = 1; step();
    check("pop2_flags", 16'(bus.flags), 16'h9);
    check("pop2_empty", 16'(bus.stack_empty), 16'h1);
    check("pop2_err",   16'(bus.err), 16'h0);
    bus.flags_pop = 1; step();
    check("underflow_err",   16'(bus.err), 16'h1);
    check("underflow_flags", 16'(bus.flags), 16'h9);

    // fill the stack, overflow, then drain to confirm contents
    do_reset();
    load(4'h1); step();
    for (int i = 0; i < 4; i++) begin
      bus.flags_push = 1; load(4'(i + 2)); step();
    end
    check("full_full", 16'(bus.stack_full), 16'h1);
    check("full_err",  16'(bus.err), 16'h0);
    check("full_flags", 16'(bus.flags), 16'h5);
    bus.flags_push = 1; step();
    check("overflow_err", 16'(bus.err), 16'h1);
    for (int i = 0; i < 4; i++) begin
      bus.flags_pop = 1; step();
      check($sformatf("drain%0d_flags", i), 16'(bus.flags), 16'(4 - i));
    end
    check("drain_empty", 16'(bus.stack_empty), 16'h1);

    // push and pop together
    do_reset();
    load(4'hA); step();
    bus.flags_push = 1; step();
    load(4'h5); bus.flags_push = 1; bus.flags_pop = 1; step();
    check("pushpop_err",   16'(bus.err), 16'h1);
    check("pushpop_flags", 16'(bus.flags), 16'h5);
    check("pushpop_empty", 16'(bus.stack_empty), 16'h0);
    bus.flags_pop = 1; step();
    check("pushpop_top",   16'(bus.flags), 16'hA);
    check("pushpop_empty2", 16'(bus.stack_empty), 16'h1);

    // push concurrent with ALU update saves the pre-update flags
    do_reset();
    load(4'h6); step();
    bus.issue_set_flags = 1; step();
    bus.flags_push = 1; wb(0, 16'h7FFF, 16'h0001, 16'h8000, 0); step();
    check("push_alu_flags", 16'(bus.flags), 16'h9);
    bus.flags_pop = 1; step();
    check("push_alu_saved", 16'(bus.flags), 16'h6);
    check("push_alu_err",   16'(bus.err), 16'h0);

    // pending saturation and underflow
    do_reset();
    repeat (4) begin bus.issue_set_flags = 1; step(); end
    check("sat_err",   16'(bus.err), 16'h1);
    check("sat_valid", 16'(bus.flags_valid), 16'h0);
    repeat (2) begin wb(0, 16'h0001, 16'h0001, 16'h0002, 0); step(); end
    check("sat_dec2_valid", 16'(bus.flags_valid), 16'h0);
    wb(0, 16'h0001, 16'h0001, 16'h0002, 0); step();
    check("sat_dec3_valid", 16'(bus.flags_valid), 16'h1);
    do_reset();
    check("rst2_err",   16'(bus.err), 16'h0);
    check("rst2_valid", 16'(bus.flags_valid), 16'h1);
    check("rst2_flags", 16'(bus.flags), 16'h0);
    wb(0, 16'h0001, 16'h0001, 16'h0002, 0); step();
    check("dec_at0_err",   16'(bus.err), 16'h1);
    check("dec_at0_valid", 16'(bus.flags_valid), 16'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
